// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter arbiter: FSM state encoding,
// converter widths and the overflow saturation value.
package bcd_arb_pkg;

    localparam int BIN_W         = 10;
    localparam int BCD_W         = 12;
    localparam int FLUSH_CYC_DEF = 48;

    localparam logic [BIN_W-1:0] MAX_BIN = 10'd999;
    localparam logic [BCD_W-1:0] OVF_BCD = 12'h999;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_CHECK,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// around to the lowest set request when none lies at or above ptr.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    // NOTE: every output gets a default before the loops, so no path leaves
    // gnt_idx unassigned and no latch is inferred.
    always_comb begin
        any     = |req;
        gnt_idx = '0;
        // Descending loops: the last hit is the lowest index. The second pass
        // overrides the wrap-around pick only when a request sits at/after ptr.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) gnt_idx = PTR_W'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (PTR_W'(i) >= ptr)) gnt_idx = PTR_W'(i);
        end
    end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shares one serial binary-to-BCD converter between N_REQ requesters with a
// round-robin grant, local saturation above 999 and a post-reset flush guard.
module bcd_convert_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BIN_W     = bcd_arb_pkg::BIN_W,
    parameter int BCD_W     = bcd_arb_pkg::BCD_W,
    parameter int FLUSH_CYC = bcd_arb_pkg::FLUSH_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] bin_in,
    output logic [N_REQ-1:0]       ack,
    output logic [BCD_W-1:0]       bcd_out,
    output logic                   ovf,
    output logic                   busy,
    output logic                   cvt_en,
    output logic [BIN_W-1:0]       cvt_bin,
    input  logic [BCD_W-1:0]       cvt_bcd,
    input  logic                   cvt_rdy
);

    import bcd_arb_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FLUSH_CYC + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   flush_cnt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic [BIN_W-1:0]   opnd;
    logic               ovf_flag;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FLUSH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FLUSH:  if (flush_cnt == '0 || cvt_rdy) state_nxt = ST_IDLE;
            ST_IDLE:   if (pick_any)                    state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (opnd > MAX_BIN) ? ST_RESP : ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (cvt_rdy)                     state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= CNT_W'(FLUSH_CYC);
            ptr       <= '0;
            gidx      <= '0;
            opnd      <= '0;
            ovf_flag  <= 1'b0;
            cvt_bin   <= '0;
            bcd_out   <= '0;
        end else begin
            unique case (state)
                ST_FLUSH: begin
                    if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
                end
                ST_IDLE: begin
                    if (pick_any) begin
                        gidx     <= pick_idx;
                        opnd     <= bin_in[pick_idx*BIN_W +: BIN_W];
                        ovf_flag <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (opnd > MAX_BIN) begin
                        ovf_flag <= 1'b1;
                        bcd_out  <= OVF_BCD;
                    end else begin
                        cvt_bin  <= opnd;
                    end
                end
                ST_WAIT: begin
                    if (cvt_rdy) bcd_out <= cvt_bcd;
                end
                ST_RESP: begin
                    ptr <= (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (state == ST_RESP) ack[gidx] = 1'b1;
    end

    assign ovf    = (state == ST_RESP) && ovf_flag;
    assign busy   = (state != ST_IDLE);
    assign cvt_en = (state == ST_LAUNCH);

endmodule
